// File: rtl/median3x3_pipe.sv
// median3x3_pipe: 4-stage 3x3 median filter; win_* in / med_* out (valid/ready, global stall), bypass passes centre pixel, drop_cnt counts windows offered while stalled
module median3x3_pipe #(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              win_valid,
  input  logic [9*DW-1:0]   win_data,
  output logic              win_ready,
  input  logic              bypass,
  output logic              med_valid,
  input  logic              med_ready,
  output logic [DW-1:0]     med_data,
  output logic [CNT_W-1:0]  drop_cnt
);
  typedef logic [8:0][DW-1:0] win_t;
  typedef struct packed {
    logic          v;
    logic          byp;
    logic [DW-1:0] ctr;
    win_t          w;
  } stage_t;
  function automatic win_t cx(input win_t w, input logic [3:0] a, input logic [3:0] b);
    win_t r;
    r = w;
    if (w[a] > w[b]) begin
      r[a] = w[b];
      r[b] = w[a];
    end
    return r;
  endfunction
  function automatic win_t net1(input win_t w);
    win_t r;
    r = cx(w, 4'd1, 4'd2);
    r = cx(r, 4'd4, 4'd5);
    r = cx(r, 4'd7, 4'd8);
    r = cx(r, 4'd0, 4'd1);
    r = cx(r, 4'd3, 4'd4);
    r = cx(r, 4'd6, 4'd7);
    return r;
  endfunction
  function automatic win_t net2(input win_t w);
    win_t r;
    r = cx(w, 4'd1, 4'd2);
    r = cx(r, 4'd4, 4'd5);
    r = cx(r, 4'd7, 4'd8);
    r = cx(r, 4'd0, 4'd3);
    r = cx(r, 4'd5, 4'd8);
    r = cx(r, 4'd4, 4'd7);
    return r;
  endfunction
  function automatic win_t net3(input win_t w);
    win_t r;
    r = cx(w, 4'd3, 4'd6);
    r = cx(r, 4'd1, 4'd4);
    r = cx(r, 4'd2, 4'd5);
    r = cx(r, 4'd4, 4'd7);
    return r;
  endfunction
  function automatic logic [DW-1:0] net4(input win_t w);
    win_t r;
    r = cx(w, 4'd4, 4'd2);
    r = cx(r, 4'd6, 4'd4);
    r = cx(r, 4'd4, 4'd2);
    return r[4];
  endfunction
  stage_t            st1_q, st1_d, st2_q, st2_d, st3_q, st3_d;
  logic              med_valid_q, med_valid_d;
  logic [DW-1:0]     med_data_q, med_data_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic              adv;
  win_t              win_in;
  assign win_in    = win_data;
  assign adv       = !med_valid_q || med_ready;
  assign win_ready = adv;
  assign med_valid = med_valid_q;
  assign med_data  = med_data_q;
  assign drop_cnt  = drop_cnt_q;
  always_comb begin
    st1_d       = st1_q;
    st2_d       = st2_q;
    st3_d       = st3_q;
    med_valid_d = med_valid_q;
    med_data_d  = med_data_q;
    drop_cnt_d  = drop_cnt_q;
    if (adv) begin
      st1_d       = {win_valid, bypass, win_in[4], net1(win_in)};
      st2_d       = {st1_q.v, st1_q.byp, st1_q.ctr, net2(st1_q.w)};
      st3_d       = {st2_q.v, st2_q.byp, st2_q.ctr, net3(st2_q.w)};
      med_valid_d = st3_q.v;
      med_data_d  = !st3_q.v ? med_data_q : st3_q.byp ? st3_q.ctr : net4(st3_q.w);
    end else if (win_valid && drop_cnt_q != '1) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st1_q       <= '0;
      st2_q       <= '0;
      st3_q       <= '0;
      med_valid_q <= 1'b0;
      med_data_q  <= '0;
      drop_cnt_q  <= '0;
    end else begin
      st1_q       <= st1_d;
      st2_q       <= st2_d;
      st3_q       <= st3_d;
      med_valid_q <= med_valid_d;
      med_data_q  <= med_data_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end
endmodule

// File: tb/tb_median3x3_pipe.sv
// tb_median3x3_pipe: randomized and directed checks of median3x3_pipe against a sort-based pipeline model
module tb_median3x3_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        win_valid = 1'b0;
  logic [71:0] win_data = '0;
  logic        win_ready;
  logic        bypass = 1'b0;
  logic        med_valid;
  logic        med_ready = 1'b1;
  logic [7:0]  med_data;
  logic [15:0] drop_cnt;
  logic        wv2 = 1'b0;
  logic        wr2;
  logic        mv2;
  logic [7:0]  md2;
  logic [1:0]  dc2;
  int vectors = 0;
  int errors = 0;
  logic [7:0] got_q[$];
  logic       m_v[4];
  logic [7:0] m_d[4];
  logic [7:0] m_last;
  logic [15:0] m_drop;
  always #5 clk = ~clk;
  median3x3_pipe #(.DW(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .win_valid(win_valid), .win_data(win_data),
    .win_ready(win_ready), .bypass(bypass), .med_valid(med_valid),
    .med_ready(med_ready), .med_data(med_data), .drop_cnt(drop_cnt));
  median3x3_pipe #(.DW(8), .CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .win_valid(wv2), .win_data(72'h010203040506070809),
    .win_ready(wr2), .bypass(1'b0), .med_valid(mv2),
    .med_ready(1'b0), .med_data(md2), .drop_cnt(dc2));
  task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  function automatic logic [7:0] med9(input logic [71:0] w);
    logic [7:0] a[9];
    logic [7:0] t;
    for (int k = 0; k < 9; k++) a[k] = w[8*k +: 8];
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j];
          a[j] = a[j+1];
          a[j+1] = t;
        end
    return a[4];
  endfunction
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_med_valid", 72'(med_valid), 72'(0));
      chk("rst_med_data", 72'(med_data), 72'(0));
      chk("rst_drop_cnt", 72'(drop_cnt), 72'(0));
      for (int i = 0; i < 4; i++) m_v[i] = 1'b0;
      m_last = '0;
      m_drop = '0;
    end else begin
      chk("win_ready", 72'(win_ready), 72'(!m_v[3] || med_ready));
      chk("med_valid", 72'(med_valid), 72'(m_v[3]));
      chk("med_data", 72'(med_data), 72'(m_v[3] ? m_d[3] : m_last));
      chk("drop_cnt", 72'(drop_cnt), 72'(m_drop));
      if (med_valid && med_ready) got_q.push_back(med_data);
      if (!m_v[3] || med_ready) begin
        if (m_v[2]) m_last = m_d[2];
        for (int i = 3; i > 0; i--) begin
          m_v[i] = m_v[i-1];
          m_d[i] = m_d[i-1];
        end
        m_v[0] = win_valid;
        m_d[0] = bypass ? win_data[39:32] : med9(win_data);
      end else if (win_valid && m_drop != 16'hFFFF) begin
        m_drop = m_drop + 16'd1;
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [71:0] w, input logic b);
    win_valid = 1'b1;
    win_data = w;
    bypass = b;
    cyc();
    win_valid = 1'b0;
    bypass = 1'b0;
  endtask
  task automatic lat_check(input logic [7:0] e);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!med_valid && n < 10);
    chk("latency", 72'(n), 72'(4));
    chk("lat_data", 72'(med_data), 72'(e));
    @(negedge clk);
    chk("single_pulse", 72'(med_valid), 72'(0));
  endtask
  localparam logic [71:0] W_DESC = 72'h010203040506070809;
  localparam logic [71:0] W_MIX  = 72'h0AC80AC8C80A0A0AC8;
  localparam logic [71:0] W_FF   = {72{1'b1}};
  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [95:0] r;
    logic [71:0] w;
    int n;
    chk("model_desc", 72'(med9(W_DESC)), 72'(5));
    chk("model_mix", 72'(med9(W_MIX)), 72'(10));
    chk("model_ff", 72'(med9(W_FF)), 72'(255));
    chk("model_dup", 72'(med9(72'h000000030303030303)), 72'(3));
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    send(W_DESC, 1'b0);
    lat_check(8'd5);
    chk("t1_drop", 72'(drop_cnt), 72'(0));
    cyc();
    got_q.delete();
    send(W_MIX, 1'b0);
    send(W_FF, 1'b0);
    repeat (7) cyc();
    chk("t2_count", 72'(got_q.size()), 72'(2));
    if (got_q.size() == 2) begin
      chk("t2_first", 72'(got_q[0]), 72'(10));
      chk("t2_second", 72'(got_q[1]), 72'(255));
    end
    got_q.delete();
    send(W_MIX, 1'b1);
    send(W_FF, 1'b0);
    repeat (7) cyc();
    chk("t3_count", 72'(got_q.size()), 72'(2));
    if (got_q.size() == 2) begin
      chk("t3_first", 72'(got_q[0]), 72'(200));
      chk("t3_second", 72'(got_q[1]), 72'(255));
    end
    got_q.delete();
    med_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send({9{8'(k * 11)}}, 1'b0);
    n = 0;
    while (win_ready && n < 10) begin
      cyc();
      n++;
    end
    chk("stall_ready", 72'(win_ready), 72'(0));
    win_valid = 1'b1;
    win_data = W_FF;
    cyc();
    cyc();
    win_valid = 1'b0;
    @(negedge clk);
    chk("stall_drops", 72'(drop_cnt), 72'(2));
    chk("stall_hold", 72'(med_data), 72'(11));
    cyc();
    med_ready = 1'b1;
    repeat (8) cyc();
    chk("stall_count", 72'(got_q.size()), 72'(4));
    if (got_q.size() == 4)
      for (int k = 0; k < 4; k++) chk("stall_order", 72'(got_q[k]), 72'((k + 1) * 11));
    wv2 = 1'b1;
    n = 0;
    while (wr2 && n < 10) begin
      cyc();
      n++;
    end
    chk("sat_stalled", 72'(wr2), 72'(0));
    repeat (2) cyc();
    wv2 = 1'b0;
    @(negedge clk);
    chk("sat_two", 72'(dc2), 72'(2));
    cyc();
    wv2 = 1'b1;
    repeat (4) cyc();
    wv2 = 1'b0;
    @(negedge clk);
    chk("sat_stick", 72'(dc2), 72'(3));
    cyc();
    got_q.delete();
    send(W_DESC, 1'b0);
    send(W_MIX, 1'b0);
    send(W_FF, 1'b0);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    repeat (8) cyc();
    @(negedge clk);
    chk("rst_no_out", 72'(got_q.size()), 72'(0));
    chk("rst_drop", 72'(drop_cnt), 72'(0));
    cyc();
    send(W_MIX, 1'b0);
    lat_check(8'd10);
    cyc();
    for (int it = 0; it < 4000; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        r = {$urandom(), $urandom(), $urandom()};
        w = r[71:0];
      end else begin
        for (int k = 0; k < 9; k++) w[8*k +: 8] = 8'($urandom_range(0, 3));
      end
      win_valid = ($urandom_range(0, 3) != 0);
      win_data = w;
      bypass = ($urandom_range(0, 7) == 0);
      med_ready = (it % 200 > 190) ? 1'b0 : ($urandom_range(0, 2) != 0);
      cyc();
    end
    win_valid = 1'b0;
    med_ready = 1'b1;
    repeat (10) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
